// File: rtl/wptr_full_gen.sv
// ---------------------------------------------------------------------------
// wptr_full_gen -- write-side pointer generator for an asynchronous FIFO.
//
// Runs entirely in the write clock domain. A binary write counter (wbin)
// advances on every accepted write. From it the block produces:
//   - a registered Gray pointer for the read-domain synchronizer
//   - the RAM write address
//   - a registered full flag, computed against the read pointer that has
//     already been synchronized into this domain
//
// Parameters
//   N          pointer width including the wrap bit (depth D = 2**(N-1))
//   AF_MARGIN  almost-full margin, used only with WPTR_ALMOST_FULL_EN
//
// Ports
//   clk             in   write-domain clock
//   rst             in   synchronous active-high reset
//   winc            in   write request (dropped while full)
//   rptr_gray_sync  in   N-bit Gray read pointer, already synchronized
//   wptr_gray       out  N-bit registered Gray write pointer
//   waddr           out  N-1 bit RAM write address (wbin[N-2:0])
//   full            out  registered full flag
//   almost_full     out  registered almost-full flag
//
// Build option
//   WPTR_ALMOST_FULL_EN  when defined, almost_full is asserted once the
//                        occupancy reaches D - AF_MARGIN; when undefined,
//                        almost_full is constant 0 and no Gray-to-binary
//                        converter is built.
// ---------------------------------------------------------------------------
module wptr_full_gen #(
   parameter int N         = 9,
   parameter int AF_MARGIN = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         winc,
   input  logic [N-1:0] rptr_gray_sync,
   output logic [N-1:0] wptr_gray,
   output logic [N-2:0] waddr,
   output logic         full,
   output logic         almost_full
);

   localparam int D = 1 << (N - 1);

   logic [N-1:0] wbin;
   logic [N-1:0] wbin_next;
   logic [N-1:0] wgray_next;
   logic         wr_acc;
   logic         full_next;

   // A write while full is dropped outright: counter, pointer and flag hold.
   assign wr_acc     = winc & ~full;
   assign wbin_next  = wbin + {{(N-1){1'b0}}, wr_acc};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;

   // Full when the next write pointer equals the read pointer one lap ahead.
   // In Gray code "one lap ahead" means the top two bits inverted.
   assign full_next  = (wgray_next ==
                        {~rptr_gray_sync[N-1:N-2], rptr_gray_sync[N-3:0]});

   // The RAM is written at the pre-increment address of the accepted cycle.
   assign waddr = wbin[N-2:0];

   // Stage boundary: pointer and flag registers. wptr_gray is driven straight
   // from a flop so the read-domain synchronizer never sees glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin      <= '0;
         wptr_gray <= '0;
         full      <= 1'b0;
      end else begin
         wbin      <= wbin_next;
         wptr_gray <= wgray_next;
         full      <= full_next;
      end
   end

`ifdef WPTR_ALMOST_FULL_EN

   localparam logic [N-1:0] AF_LEVEL = N'(D - AF_MARGIN);

   // Gray to binary: each binary bit is the XOR of all Gray bits above and
   // including it, accumulated from the MSB downward.
   function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [N-1:0] rptr_bin;
   logic [N-1:0] occ_next;
   logic         af_next;
   logic         af_q;

   // Modulo-2^N subtraction gives the occupancy directly, including across
   // the wrap of either pointer.
   assign rptr_bin = gray2bin(rptr_gray_sync);
   assign occ_next = wbin_next - rptr_bin;
   assign af_next  = (occ_next >= AF_LEVEL);

   // Stage boundary: almost-full register.
   always_ff @(posedge clk) begin
      if (rst) begin
         af_q <= 1'b0;
      end else begin
         af_q <= af_next;
      end
   end

   assign almost_full = af_q;

`else

   // Feature disabled: the margin only feeds a configuration sanity term
   // that folds to constant 0 together with the output.
   localparam logic AF_CFG_OK = (AF_MARGIN <= D);

   assign almost_full = 1'b0 & AF_CFG_OK;

`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// ---------------------------------------------------------------------------
// tb_wptr_full_gen -- directed self-checking bench for wptr_full_gen.
// Covers reset, fill to full, full release, Gray wrap-around with one-bit
// steps, mid-operation reset and (when WPTR_ALMOST_FULL_EN is defined) the
// almost-full threshold. Expected values are hand constants plus a small
// reference count of accepted writes.
// ---------------------------------------------------------------------------
module tb_wptr_full_gen;

   localparam int N = 9;

`ifdef WPTR_ALMOST_FULL_EN
   localparam bit AF_EN = 1'b1;
`else
   localparam bit AF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         winc;
   logic [N-1:0] rptr_gray_sync;
   logic [N-1:0] wptr_gray;
   logic [N-2:0] waddr;
   logic         full;
   logic         almost_full;

   int errors = 0;
   int checks = 0;

   wptr_full_gen #(.N(N), .AF_MARGIN(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .winc           (winc),
      .rptr_gray_sync (rptr_gray_sync),
      .wptr_gray      (wptr_gray),
      .waddr          (waddr),
      .full           (full),
      .almost_full    (almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] gray_of(input int b);
      logic [N-1:0] v;
      v = N'(b);
      return v ^ (v >> 1);
   endfunction

   // Reference almost-full: occupancy after the edge vs. D - 4.
   function automatic logic exp_af(input int wb, input logic [N-1:0] rg);
      int   rb;
      logic acc;
      rb  = 0;
      acc = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         acc = acc ^ rg[i];
         if (acc) rb = rb | (1 << i);
      end
      return AF_EN && (((wb - rb) & 511) >= 252);
   endfunction

   int           mw;
   logic [N-1:0] prev;
   logic [N-1:0] h1;
   bit           seen_wrap;

   initial begin
      // ---- reset with winc held high
      rst = 1'b1;
      winc = 1'b1;
      rptr_gray_sync = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_gray", 32'(wptr_gray), 32'h000);
         check("rst_waddr", 32'(waddr), 32'h0);
         check("rst_full", 32'(full), 32'h0);
         check("rst_af", 32'(almost_full), 32'h0);
      end

      // ---- fill 256 entries against rptr = 0
      rst = 1'b0;
      mw  = 0;
      for (int c = 1; c <= 256; c++) begin
         winc = 1'b1;
         tick();
         mw = c;
         check("fill_gray", 32'(wptr_gray), 32'(gray_of(mw)));
         check("fill_waddr", 32'(waddr), 32'(mw & 255));
         check("fill_full", 32'(full), 32'(c == 256));
         check("fill_af", 32'(almost_full), 32'(exp_af(mw, rptr_gray_sync)));
         if (c == 251) check("af_251", 32'(almost_full), 32'h0);
         if (c == 252) begin
            check("af_252", 32'(almost_full), 32'(AF_EN));
            check("af_252_full", 32'(full), 32'h0);
         end
      end
      check("full_gray", 32'(wptr_gray), 32'h180);
      check("full_waddr", 32'(waddr), 32'h0);
      check("full_flag", 32'(full), 32'h1);

      // write while full is dropped
      winc = 1'b1;
      tick();
      check("drop_gray", 32'(wptr_gray), 32'h180);
      check("drop_full", 32'(full), 32'h1);
      check("drop_af", 32'(almost_full), 32'(AF_EN));

      // ---- release: read pointer advances by one
      winc = 1'b0;
      rptr_gray_sync = 9'h001;
      tick();
      check("rel_full", 32'(full), 32'h0);
      check("rel_gray", 32'(wptr_gray), 32'h180);
      check("rel_af", 32'(almost_full), 32'(AF_EN));
      winc = 1'b1;
      tick();
      check("refill_gray", 32'(wptr_gray), 32'h181);
      check("refill_full", 32'(full), 32'h1);
      tick();
      check("refill_hold", 32'(wptr_gray), 32'h181);

      // ---- reset, then 600 writes with rptr trailing wptr
      rst = 1'b1;
      winc = 1'b0;
      rptr_gray_sync = '0;
      tick();
      check("rst2_gray", 32'(wptr_gray), 32'h000);
      check("rst2_full", 32'(full), 32'h0);
      rst = 1'b0;
      mw = 0;
      h1 = '0;
      seen_wrap = 1'b0;
      for (int c = 1; c <= 600; c++) begin
         rptr_gray_sync = h1;
         h1   = wptr_gray;
         prev = wptr_gray;
         winc = 1'b1;
         tick();
         mw = c & 511;
         check("wrap_gray", 32'(wptr_gray), 32'(gray_of(mw)));
         check("wrap_hd1", 32'($countones(prev ^ wptr_gray)), 32'd1);
         check("wrap_full", 32'(full), 32'h0);
         check("wrap_af", 32'(almost_full), 32'(exp_af(mw, rptr_gray_sync)));
         if (prev == 9'h100 && wptr_gray == 9'h000) seen_wrap = 1'b1;
      end
      check("wrap_seen", 32'(seen_wrap), 32'h1);

      // ---- mid-operation reset after 100 writes
      rst = 1'b1;
      winc = 1'b0;
      rptr_gray_sync = '0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         winc = 1'b1;
         tick();
      end
      check("mid_gray", 32'(wptr_gray), 32'h056);
      check("mid_waddr", 32'(waddr), 32'd100);
      rst = 1'b1;
      winc = 1'b1;
      tick();
      check("mid_rst_gray", 32'(wptr_gray), 32'h000);
      check("mid_rst_waddr", 32'(waddr), 32'h0);
      check("mid_rst_full", 32'(full), 32'h0);
      check("mid_rst_af", 32'(almost_full), 32'h0);
      rst = 1'b0;
      winc = 1'b1;
      tick();
      check("post_rst_gray", 32'(wptr_gray), 32'h001);
      check("post_rst_waddr", 32'(waddr), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
